// File: rtl/layer_serializer_if.sv
// Bus between one fully-connected layer's neuron outputs and the serializer,
// plus the serial word stream the serializer drives towards the next layer.
interface layer_serializer_if #(
    parameter int nn         = 30,
    parameter int data_width = 16
);
    logic [nn-1:0]            i_valid;
    logic [nn*data_width-1:0] i_data_flat;
    logic                     x_valid;
    logic [data_width-1:0]    x_out;
    logic                     x_last;
    logic                     busy;
    logic                     overrun;

    // Upstream layer / environment side
    modport master (
        output i_valid,
        output i_data_flat,
        input  x_valid,
        input  x_out,
        input  x_last,
        input  busy,
        input  overrun
    );

    // Serializer side
    modport slave (
        input  i_valid,
        input  i_data_flat,
        output x_valid,
        output x_out,
        output x_last,
        output busy,
        output overrun
    );
endinterface

// File: rtl/layer_serializer.sv
// Parallel-to-serial stage between two fully-connected layers. Captures each
// neuron's result on its valid strobe, and once every neuron has reported,
// replays the results one word per cycle (neuron 0 first) with no gaps.
// Strobes that repeat an already captured neuron, or that arrive while a
// burst is being replayed, are dropped and flagged with a one-cycle overrun.
module layer_serializer #(
    parameter int nn         = 30,
    parameter int data_width = 16
) (
    input  logic               clk,
    input  logic               rst,
    layer_serializer_if.slave  bus
);
    localparam int idx_w = $clog2(nn);
    localparam logic [idx_w-1:0] last_idx = idx_w'(nn - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        SHIFT   = 1'b1
    } state_t;

    state_t                  state_r;
    logic [nn-1:0]           mask_r;
    logic [idx_w-1:0]        idx_r;
    logic [data_width-1:0]   buf_r [nn];
    logic                    overrun_r;

    logic                    x_valid_s;
    logic [data_width-1:0]   x_out_s;
    logic                    x_last_s;

    // Capture/replay state machine with the registered overrun flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= COLLECT;
            mask_r    <= '0;
            idx_r     <= '0;
            overrun_r <= 1'b0;
            for (int j = 0; j < nn; j++) begin
                buf_r[j] <= '0;
            end
        end else begin
            case (state_r)
                COLLECT: begin
                    // Only first arrivals are written; duplicates keep the old word
                    for (int j = 0; j < nn; j++) begin
                        if (bus.i_valid[j] && !mask_r[j]) begin
                            buf_r[j] <= bus.i_data_flat[j*data_width +: data_width];
                        end
                    end
                    overrun_r <= |(bus.i_valid & mask_r);
                    if (&(mask_r | bus.i_valid)) begin
                        state_r <= SHIFT;
                        idx_r   <= '0;
                        mask_r  <= '0;
                    end else begin
                        mask_r  <= mask_r | bus.i_valid;
                    end
                end
                SHIFT: begin
                    // Nothing is captured while replaying; any strobe is lost
                    overrun_r <= |bus.i_valid;
                    if (idx_r == last_idx) begin
                        state_r <= COLLECT;
                        idx_r   <= '0;
                    end else begin
                        idx_r   <= idx_r + idx_w'(1);
                    end
                end
                default: begin
                    state_r   <= COLLECT;
                    mask_r    <= '0;
                    idx_r     <= '0;
                    overrun_r <= 1'b0;
                end
            endcase
        end
    end

    // Serial outputs decoded purely from registered state, zero when idle
    always_comb begin
        x_valid_s = 1'b0;
        x_out_s   = '0;
        x_last_s  = 1'b0;
        if (state_r == SHIFT) begin
            x_valid_s = 1'b1;
            x_out_s   = buf_r[idx_r];
            x_last_s  = (idx_r == last_idx);
        end else begin
            x_valid_s = 1'b0;
            x_out_s   = '0;
            x_last_s  = 1'b0;
        end
    end

    assign bus.x_valid = x_valid_s;
    assign bus.x_out   = x_out_s;
    assign bus.x_last  = x_last_s;
    assign bus.busy    = x_valid_s;
    assign bus.overrun = overrun_r;
endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer: a 4-neuron instance exercises the
// capture/replay/overrun behaviour, a 30-neuron instance the default size.
module tb_layer_serializer;
    logic clk;
    logic rst;

    layer_serializer_if #(.nn(4),  .data_width(16)) bus4  ();
    layer_serializer_if #(.nn(30), .data_width(16)) bus30 ();

    layer_serializer #(.nn(4), .data_width(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    layer_serializer #(.nn(30), .data_width(16)) dut30 (
        .clk (clk),
        .rst (rst),
        .bus (bus30)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        last;
    } sb_item_t;

    sb_item_t sb [$];
    sb_item_t mon_item;
    bit       ovr_at [int];
    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;
    bit       mon_en = 1'b0;
    logic     exp_ovr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: value seen at a falling edge = rising edges so far
    always @(posedge clk) cyc = cyc + 1;

    // Monitor for the 4-neuron instance: words against scoreboard, idle outputs, overrun
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus4.busy !== bus4.x_valid) begin
                failures++;
                $display("FAIL busy_eq_valid: cyc=%0d busy=%b x_valid=%b", cyc, bus4.busy, bus4.x_valid);
            end
            exp_ovr = ovr_at.exists(cyc) ? 1'b1 : 1'b0;
            checks++;
            if (bus4.overrun !== exp_ovr) begin
                failures++;
                $display("FAIL overrun: cyc=%0d got %b expected %b", cyc, bus4.overrun, exp_ovr);
            end
            if (bus4.x_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: cyc=%0d got x_out=%h, expected no word", cyc, bus4.x_out);
                end else begin
                    mon_item = sb.pop_front();
                    if (mon_item.cyc != cyc || bus4.x_out !== mon_item.data || bus4.x_last !== mon_item.last) begin
                        failures++;
                        $display("FAIL word: got cyc=%0d x_out=%h x_last=%b, expected cyc=%0d x_out=%h x_last=%b",
                                 cyc, bus4.x_out, bus4.x_last, mon_item.cyc, mon_item.data, mon_item.last);
                    end
                end
            end else begin
                checks++;
                if (bus4.x_valid !== 1'b0 || bus4.x_out !== 16'h0000 || bus4.x_last !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_outputs: cyc=%0d x_valid=%b x_out=%h x_last=%b, expected 0/0000/0",
                             cyc, bus4.x_valid, bus4.x_out, bus4.x_last);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus4.i_valid     = 4'b0000;
            bus4.i_data_flat = {$urandom, $urandom};
        end
    endtask

    // One cycle of strobes; dup marks a cycle that must raise overrun next cycle
    task automatic strobe(input logic [3:0] v, input logic [63:0] d, input bit dup);
        @(negedge clk);
        bus4.i_valid     = v;
        bus4.i_data_flat = d;
        if (dup) ovr_at[cyc + 1] = 1'b1;
    endtask

    task automatic push_burst(input logic [63:0] words, input int start);
        sb_item_t it;
        for (int k = 0; k < 4; k++) begin
            it.cyc  = start + k;
            it.data = words[k*16 +: 16];
            it.last = (k == 3);
            sb.push_back(it);
        end
    endtask

    task automatic test_reset;
        rst               = 1'b0;
        bus4.i_valid      = 4'($urandom);
        bus4.i_data_flat  = {$urandom, $urandom};
        bus30.i_valid     = '0;
        bus30.i_data_flat = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus4.x_valid, bus4.x_last, bus4.busy, bus4.overrun, bus4.x_out} !== 20'h00000) begin
                failures++;
                $display("FAIL reset_outputs: got valid/last/busy/ovr=%b%b%b%b x_out=%h, expected all 0",
                         bus4.x_valid, bus4.x_last, bus4.busy, bus4.overrun, bus4.x_out);
            end
            bus4.i_valid     = 4'($urandom);
            bus4.i_data_flat = {$urandom, $urandom};
        end
        @(negedge clk);
        rst          = 1'b1;
        bus4.i_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if ({bus4.x_valid, bus4.x_last, bus4.busy, bus4.overrun, bus4.x_out} !== 20'h00000) begin
            failures++;
            $display("FAIL after_release: got valid/last/busy/ovr=%b%b%b%b x_out=%h, expected all 0",
                     bus4.x_valid, bus4.x_last, bus4.busy, bus4.overrun, bus4.x_out);
        end
        mon_en = 1'b1;
        idle(6);
    endtask

    task automatic test_simultaneous;
        idle(2);
        strobe(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b0);
        push_burst({16'h0004, 16'h0003, 16'h0002, 16'h0001}, cyc + 1);
        idle(7);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL simultaneous_done: %0d words missing, expected 0", sb.size());
        end
    endtask

    task automatic test_staggered;
        strobe(4'b0100, {16'hEEEE, 16'hAAAA, 16'hEEEE, 16'hEEEE}, 1'b0);
        idle(2);
        strobe(4'b1001, {16'hDDDD, 16'h5555, 16'h5555, 16'h1111}, 1'b0);
        idle(3);
        strobe(4'b0010, {16'h0BAD, 16'h0BAD, 16'h7FFF, 16'h0BAD}, 1'b0);
        push_burst({16'hDDDD, 16'hAAAA, 16'h7FFF, 16'h1111}, cyc + 1);
        idle(7);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL staggered_done: %0d words missing, expected 0", sb.size());
        end
    endtask

    task automatic test_duplicate;
        int t;
        strobe(4'b0001, {48'h0, 16'h0005}, 1'b0);
        strobe(4'b0001, {48'h0, 16'h0009}, 1'b1);
        idle(1);
        strobe(4'b1110, {16'h0303, 16'h0202, 16'h0101, 16'h0009}, 1'b0);
        t = cyc;
        push_burst({16'h0303, 16'h0202, 16'h0101, 16'h0005}, t + 1);
        // Late strobe on neuron 1 while the burst is replaying
        strobe(4'b0010, {16'h0, 16'h0, 16'h4444, 16'h0}, 1'b1);
        idle(5);
        // Neuron 1 still outstanding: nothing may be emitted
        strobe(4'b1101, {16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00}, 1'b0);
        idle(5);
        strobe(4'b0010, {16'h0, 16'h0, 16'h0E01, 16'h0}, 1'b0);
        push_burst({16'h0D03, 16'h0D02, 16'h0E01, 16'h0D00}, cyc + 1);
        idle(7);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL duplicate_done: %0d words missing, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        strobe(4'b1111, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 1'b0);
        push_burst({16'hA003, 16'hA002, 16'hA001, 16'hA000}, cyc + 1);
        idle(4);
        strobe(4'b1111, {16'hB003, 16'hB002, 16'hB001, 16'hB000}, 1'b0);
        push_burst({16'hB003, 16'hB002, 16'hB001, 16'hB000}, cyc + 1);
        idle(8);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL back_to_back_done: %0d words missing, expected 0", sb.size());
        end
        // New set arrives during the x_last cycle: dropped, no second burst
        strobe(4'b1111, {16'hC003, 16'hC002, 16'hC001, 16'hC000}, 1'b0);
        push_burst({16'hC003, 16'hC002, 16'hC001, 16'hC000}, cyc + 1);
        idle(3);
        strobe(4'b1111, {16'hD003, 16'hD002, 16'hD001, 16'hD000}, 1'b1);
        idle(9);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL early_set_done: %0d words missing, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_burst;
        strobe(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b0);
        push_burst({16'h0004, 16'h0003, 16'h0002, 16'h0001}, cyc + 1);
        idle(1);
        @(negedge clk);
        rst          = 1'b0;
        bus4.i_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (sb.size() != 2) begin
            failures++;
            $display("FAIL mid_burst_words: got %0d words left, expected 2", sb.size());
        end
        checks++;
        if (bus4.x_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_burst_abort: got x_valid=%b expected 0", bus4.x_valid);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        idle(8);
    endtask

    task automatic test_nn30;
        logic [30*16-1:0] d30;
        logic [15:0]      w;
        for (int j = 0; j < 30; j++) begin
            w = 16'h1000 + 16'(j) * 16'd3;
            d30[j*16 +: 16] = w;
        end
        @(negedge clk);
        bus30.i_valid     = {30{1'b1}};
        bus30.i_data_flat = d30;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            bus30.i_valid = '0;
            w = 16'h1000 + 16'(k) * 16'd3;
            checks++;
            if (bus30.x_valid !== 1'b1 || bus30.x_out !== w || bus30.x_last !== (k == 29)) begin
                failures++;
                $display("FAIL nn30_word%0d: got valid=%b x_out=%h last=%b, expected 1 %h %b",
                         k, bus30.x_valid, bus30.x_out, bus30.x_last, w, (k == 29));
            end
        end
        @(negedge clk);
        checks++;
        if (bus30.x_valid !== 1'b0 || bus30.busy !== 1'b0) begin
            failures++;
            $display("FAIL nn30_end: got x_valid=%b busy=%b, expected 0 0", bus30.x_valid, bus30.busy);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_staggered();
        test_duplicate();
        test_back_to_back();
        test_reset_mid_burst();
        test_nn30();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_serializer.md
# layer_serializer

Parallel-to-serial stage between two fully-connected layers of the NPU. Collects the `nn` per-neuron results of one layer as each neuron's valid strobe fires, then replays them one word per cycle on a single `x_valid`/`x_in`-style stream. The next layer consumes this stream; it broadcasts each word to all of its neurons. No backpressure is needed because downstream neurons accept one input per cycle unconditionally.

## Interface
- `nn`, 30: number of neurons in the upstream layer, and the number of words per output burst; legal range 2..1024.
- `data_width`, 16: width of each neuron result.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-low.
- `i_valid` in `nn`: per-neuron result strobe from the upstream layer's `o_valid`.
- `i_data_flat` in `nn*data_width`: neuron j's result at `[j*data_width +: data_width]`; sampled only where `i_valid[j]`=1.
- `x_valid` out 1: a serial word is present this cycle.
- `x_out` out `data_width`: serial word, neuron 0 first.
- `x_last` out 1: high with the word of neuron `nn-1`.
- `busy` out 1: high in SHIFT state.
- `overrun` out 1: one-cycle pulse when a strobe is dropped.

## Operation
- **Storage:**
  - `buf[nn][data_width]`: captured results.
  - `mask[nn]`: captured flags.
  - `idx`: a `$clog2(nn)`-bit counter.
  - `state` ∈ {COLLECT, SHIFT}.
- **COLLECT state:**
  - For each j with `i_valid[j]`=1 and `mask[j]`=0: write slice j into `buf[j]` and set `mask[j]`.
  - Strobes may arrive in any order, any number per cycle, and spread over any number of cycles.
  - For each j with `i_valid[j]`=1 and `mask[j]`=1 (a duplicate): ignore the data, keep `buf[j]`, and pulse `overrun` next cycle.
  - If `mask | (i_valid & ~mask)` equals all ones at the end of a cycle, transition:
    - `state` to SHIFT,
    - `idx` to 0,
    - `mask` to 0.
- **SHIFT state:**
  - `x_valid`=1.
  - `x_out`=`buf[idx]`.
  - `x_last`=(`idx`==`nn-1`).
  - `idx` increments each cycle.
  - When `idx`==`nn-1`, the state returns to COLLECT at the end of that cycle.
  - Any `i_valid` bit high during SHIFT (including the `x_last` cycle) is dropped: it is not captured, `mask` is not set, and `overrun` pulses.
- `x_out`, `x_valid`, `x_last` and `busy` are decoded from registered state only (no input-to-output combinational path).
- When `x_valid`=0, `x_out` is driven 0 and `x_last` is 0.
- `overrun` is registered and pulses once per offending cycle, regardless of how many bits offended.
- **Reset (`rst`=0 at a rising edge):**
  - State is forced to COLLECT; `mask`, `idx` and `buf` are cleared.
  - All outputs read 0 in the following cycle.
  - Reset mid-burst aborts the burst; no further words are emitted.

## Timing
- Cycle N completes the mask (last strobe seen). The first word (neuron 0) appears in cycle N+1, and neuron k appears in cycle N+1+k.
- `x_last` is high in cycle N+nn.
- Strobes are accepted again from cycle N+nn+1.
- The burst is exactly `nn` contiguous cycles with `x_valid`=1; there are no gaps.
- If all `nn` strobes arrive together in cycle N, the response is identical to staggered arrival ending in N.
- Back-to-back layers: a second full set of strobes arriving in cycle N+nn+1 produces a second burst starting N+nn+2. There is a one-idle-cycle minimum between bursts.
- `overrun` goes high in the cycle after the offending strobe, for 1 cycle.
- `busy` equals `x_valid`.

## Test plan
The bench runs with `nn`=4 and `data_width`=16 unless stated otherwise.

- **Reset:** hold `rst`=0 for 3 cycles with random `i_valid`/`i_data_flat` → `x_valid`, `x_last`, `busy`, `overrun` all 0 and `x_out`=0 during reset and 1 cycle after release; no burst follows.
- **Simultaneous capture:** `i_valid`=4'b1111 with data {0x0004,0x0003,0x0002,0x0001} (neuron 3..0) in cycle 10 → `x_out` = 0x0001, 0x0002, 0x0003, 0x0004 in cycles 11–14; `x_valid` high for exactly those 4 cycles; `x_last` only in 14.
- **Staggered, out-of-order:** neuron 2 = 0xAAAA in cycle 5, neurons 0 and 3 = 0x1111 and 0xDDDD in cycle 8, neuron 1 = 0x7FFF in cycle 12 → burst in cycles 13–16 with words 0x1111, 0x7FFF, 0xAAAA, 0xDDDD.
- **Duplicate and late strobes:**
  - Neuron 0 = 0x0005 in cycle 2, neuron 0 = 0x0009 again in cycle 3 → `overrun` pulse in cycle 4; the burst later emits 0x0005 for neuron 0.
  - `i_valid[1]` during SHIFT → `overrun` pulse; the next burst still waits for all 4 strobes.
- **Back-to-back bursts:** all strobes in cycle 10 (burst in 11–14), new full set in cycle 15 → second burst in cycles 16–19 with the new data and no overrun. The same full set in cycle 14 instead → `overrun` in 15 and no second burst.
- **Reset mid-burst, then default size:** assert `rst`=0 in cycle 12 of the burst from the simultaneous-capture case → `x_valid`=0 from cycle 13 and no further words. Then run with `nn`=30: a single full capture yields 30 contiguous words with `x_last` on the 30th.
